// File: rtl/edge_event_capture.sv
// Per-bit edge detector with one-cycle pulse outputs and a timestamped event FIFO.
// Each cycle with at least one edge pushes one {timestamp, rose mask, fell mask} entry.
module edge_event_capture #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           sig_in,
  output logic [WIDTH-1:0]           rose_o,
  output logic [WIDTH-1:0]           fell_o,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_ts,
  output logic [WIDTH-1:0]           evt_rose,
  output logic [WIDTH-1:0]           evt_fell,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: an entry leaves the FIFO on a posedge where evt_valid && evt_ready;
  // head data holds steady while evt_valid is high and evt_ready is low.

  logic [WIDTH-1:0] prev_q;
  logic             armed;
  logic [TS_W-1:0]  ts_q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] f;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             drop;

  logic [TS_W-1:0]  ts_mem   [DEPTH];
  logic [WIDTH-1:0] rose_mem [DEPTH];
  logic [WIDTH-1:0] fell_mem [DEPTH];

  // The first sampled cycle after reset only loads prev_q, so nothing is reported for it.
  always_comb begin
    r = '0;
    f = '0;
    if (armed) begin
      r = sig_in & ~prev_q;
      f = ~sig_in & prev_q;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = |(r | f);
  assign pop   = !empty && evt_ready;
  // When full, a simultaneous pop frees the head slot, which is also the write slot.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign evt_valid = !empty;
  assign evt_count = wr_ptr - rd_ptr;
  assign evt_ts    = ts_mem[rd_ptr[AW-1:0]];
  assign evt_rose  = rose_mem[rd_ptr[AW-1:0]];
  assign evt_fell  = fell_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      armed  <= 1'b0;
      rose_o <= '0;
      fell_o <= '0;
      ts_q   <= '0;
    end else begin
      prev_q <= sig_in;
      armed  <= 1'b1;
      rose_o <= r;
      fell_o <= f;
      ts_q   <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ts_mem[wr_ptr[AW-1:0]]   <= ts_q;
      rose_mem[wr_ptr[AW-1:0]] <= r;
      fell_mem[wr_ptr[AW-1:0]] <= f;
    end
  end

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture: pulses, event entries, overflow and reset behaviour.
module tb_edge_event_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sig_in;
  logic [31:0] rose_o;
  logic [31:0] fell_o;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_ts;
  logic [31:0] evt_rose;
  logic [31:0] evt_fell;
  logic [2:0]  evt_count;
  logic        ovf;
  logic        ovf_clr;

  int total = 0;
  int bad   = 0;
  logic [15:0] cyc;
  logic [15:0] exp_ts;
  logic [15:0] e_ts [5];
  logic [31:0] e_r  [5];
  logic [31:0] e_f  [5];
  logic [31:0] vals [5];

  edge_event_capture dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .rose_o(rose_o), .fell_o(fell_o),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_rose(evt_rose),
    .evt_fell(evt_fell), .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Posedges seen since reset release; the timestamp a new edge will carry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 16'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; sig_in = 32'hFFFF_FFFF; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    check("rst_rose", rose_o, 0);
    check("rst_fell", fell_o, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_count", evt_count, 0);
    check("rst_ovf", ovf, 0);

    // Release with all ones held: no edges ever.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ones_rose", rose_o, 0);
      check("ones_fell", fell_o, 0);
      check("ones_valid", evt_valid, 0);
    end

    evt_ready = 1'b1;
    sig_in = 32'h0; exp_ts = cyc;
    tick();
    check("allfell_fell", fell_o, 32'hFFFF_FFFF);
    check("allfell_rose", rose_o, 0);
    check("allfell_valid", evt_valid, 1);
    check("allfell_ts", evt_ts, exp_ts);
    check("allfell_efell", evt_fell, 32'hFFFF_FFFF);
    check("allfell_erose", evt_rose, 0);
    tick();
    check("allfell_pulse_end", fell_o, 0);
    check("allfell_popped", evt_valid, 0);

    sig_in = 32'h1; exp_ts = cyc;
    tick();
    check("bit0_rose", rose_o, 32'h1);
    check("bit0_fell", fell_o, 0);
    check("bit0_ts", evt_ts, exp_ts);
    check("bit0_erose", evt_rose, 32'h1);
    check("bit0_efell", evt_fell, 0);
    tick();
    check("bit0_pulse_end", rose_o, 0);
    check("bit0_popped", evt_valid, 0);
    check("empty_pop_count", evt_count, 0);

    sig_in = 32'hF0;
    tick();
    tick();
    sig_in = 32'h0F; exp_ts = cyc;
    tick();
    check("mix_rose", rose_o, 32'h0F);
    check("mix_fell", fell_o, 32'hF0);
    check("mix_count", evt_count, 1);
    check("mix_ts", evt_ts, exp_ts);
    check("mix_erose", evt_rose, 32'h0F);
    check("mix_efell", evt_fell, 32'hF0);
    tick();
    check("mix_popped", evt_valid, 0);

    // Five edges with the consumer stalled: the fifth is dropped.
    evt_ready = 1'b0;
    vals[0] = 32'h00; vals[1] = 32'h01; vals[2] = 32'h03; vals[3] = 32'h07; vals[4] = 32'h0F;
    e_r[0] = 32'h0; e_r[1] = 32'h1; e_r[2] = 32'h2; e_r[3] = 32'h4; e_r[4] = 32'h8;
    e_f[0] = 32'h0F; e_f[1] = 32'h0; e_f[2] = 32'h0; e_f[3] = 32'h0; e_f[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      sig_in = vals[i]; e_ts[i] = cyc;
      tick();
      if (i == 3) begin
        check("fill4_count", evt_count, 4);
        check("fill4_ovf", ovf, 0);
      end
    end
    check("ovf_count", evt_count, 4);
    check("ovf_set", ovf, 1);
    check("ovf_head_ts", evt_ts, e_ts[0]);
    check("ovf_head_fell", evt_fell, e_f[0]);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    check("ovf_clr_count", evt_count, 4);

    // Full FIFO, edge and pop together: new entry replaces the popped head at the tail.
    sig_in = 32'h1F; e_ts[4] = cyc; e_r[4] = 32'h10; e_f[4] = 32'h0;
    evt_ready = 1'b1;
    check("fullpop_head_ts", evt_ts, e_ts[0]);
    check("fullpop_head_rose", evt_rose, e_r[0]);
    tick();
    check("fullpop_count", evt_count, 4);
    check("fullpop_ovf", ovf, 0);
    for (int i = 1; i < 5; i++) begin
      check("drain_valid", evt_valid, 1);
      check("drain_ts", evt_ts, e_ts[i]);
      check("drain_rose", evt_rose, e_r[i]);
      check("drain_fell", evt_fell, e_f[i]);
      tick();
    end
    check("drain_empty", evt_valid, 0);
    check("drain_count", evt_count, 0);

    // Overflow drop coinciding with ovf_clr: the set wins.
    evt_ready = 1'b0;
    vals[0] = 32'h3F; vals[1] = 32'h7F; vals[2] = 32'hFF; vals[3] = 32'h1FF; vals[4] = 32'h3FF;
    for (int i = 0; i < 5; i++) begin
      sig_in = vals[i];
      if (i == 4) ovf_clr = 1'b1;
      tick();
    end
    ovf_clr = 1'b0;
    check("setwins_ovf", ovf, 1);
    check("setwins_count", evt_count, 4);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("three_queued", evt_count, 3);

    // Asynchronous reset mid-cycle with three entries queued.
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", evt_valid, 0);
    check("midrst_count", evt_count, 0);
    check("midrst_ovf", ovf, 0);
    sig_in = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_rose", rose_o, 0);
      check("postrst_fell", fell_o, 0);
      check("postrst_valid", evt_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_event_capture.md
EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

Interface
REQ-001 Parameter WIDTH, default 32, width of the monitored vector.
REQ-002 Parameter DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-003 Parameter TS_W, default 16, timestamp width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sig_in  input  WIDTH  monitored vector, synchronous to clk.
REQ-007 rose_o  output  WIDTH  per-bit 0->1 pulse.
REQ-008 fell_o  output  WIDTH  per-bit 1->0 pulse.
REQ-009 evt_valid  output  1  FIFO head valid.
REQ-010 evt_ready  input  1  consumer accepts head.
REQ-011 evt_ts  output  TS_W  timestamp of head event.
REQ-012 evt_rose  output  WIDTH  rose mask of head event.
REQ-013 evt_fell  output  WIDTH  fell mask of head event.
REQ-014 evt_count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-015 ovf  output  1  sticky overflow flag.
REQ-016 ovf_clr  input  1  clears ovf.

Function
REQ-017 Registers prev_q (WIDTH) and armed (1); each cycle prev_q <= sig_in; armed <= 1.
REQ-018 Edge terms: r = armed ? (sig_in & ~prev_q) : 0; f = armed ? (~sig_in & prev_q) : 0.
REQ-019 rose_o <= r and fell_o <= f, registered: 1-cycle latency; each pulse lasts exactly one cycle per transition.
REQ-020 First posedge after reset release only samples (armed=0); no edge reported, whatever sig_in holds.
REQ-021 Free-running counter ts_q (TS_W) increments every cycle, wraps 2^TS_W-1 -> 0 without flagging.
REQ-022 Push condition: (r|f) != 0; pushed entry = {ts_q, r, f} from the same cycle as the edge terms.
REQ-023 Multiple bits changing in one cycle form one entry; rising and falling bits may coexist in one entry.
REQ-024 Pop: evt_valid && evt_ready; head advances next cycle.
REQ-025 evt_valid = (evt_count != 0); evt_ts/evt_rose/evt_fell stable while evt_valid && !evt_ready.
REQ-026 Push when not full: accepted; evt_count +1 unless pop in same cycle (then unchanged).
REQ-027 Push when full with pop in same cycle: accepted, evt_count stays DEPTH, ovf unchanged.
REQ-028 Push when full without pop: entry dropped, FIFO contents unchanged, ovf <= 1.
REQ-029 Pop when empty: ignored; evt_ready has no effect while evt_valid=0.
REQ-030 ovf_clr=1 clears ovf; if ovf_clr coincides with a new overflow drop, ovf = 1 (set wins).
REQ-031 Read/write pointers clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty derived from pointer MSB compare.
REQ-032 evt_* data outputs are don't-care when evt_valid=0.

Reset
REQ-033 rst_n=0 forces immediately: prev_q=0, armed=0, rose_o=0, fell_o=0, ts_q=0, pointers=0, evt_count=0, evt_valid=0, ovf=0.
REQ-034 FIFO storage array is not reset; content is unobservable while empty.
REQ-035 Reset asserted mid-operation discards all queued events and pending pulses; no event generated for sig_in state across reset release (per REQ-020).

Verification
REQ-036 Reset release with sig_in=32'hFFFF_FFFF held -> rose_o=0, fell_o=0, evt_valid=0 for all following cycles.
REQ-037 sig_in bit0 0->1 at cycle N, evt_ready=1 -> rose_o=32'h1 for one cycle at N+1; entry {ts=N, rose=32'h1, fell=0} popped.
REQ-038 One cycle sig_in 32'h0000_00F0 -> 32'h0000_000F -> single entry rose=32'h0F, fell=32'hF0.
REQ-039 evt_ready=0, DEPTH=4, five edge cycles -> evt_count=4, ovf=1, first four entries intact in order; ovf_clr pulse -> ovf=0.
REQ-040 FIFO full, edge and evt_ready=1 same cycle -> evt_count stays 4, ovf stays 0, new entry at tail.
REQ-041 rst_n pulsed low with 3 queued entries -> evt_valid=0, evt_count=0 immediately, no spurious rose_o/fell_o after release.
